// File: rtl/sample_window_collector.sv
// Packs a valid/ready stream of samples into 8-wide windows (a = oldest) with a per-window
// shift amount; holds each full window until the consumer handshakes or a flush drops it.
module sample_window_collector #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned SAWIDTH   = 8,
  parameter int unsigned CNTWIDTH  = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SAWIDTH-1:0]   sa_in,
  input  logic                 flush,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] e,
  output logic [DATAWIDTH-1:0] f,
  output logic [DATAWIDTH-1:0] g,
  output logic [DATAWIDTH-1:0] h,
  output logic [SAWIDTH-1:0]   sa,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           fill_level,
  output logic [CNTWIDTH-1:0]  win_count
);

  localparam int unsigned NSLOTS = 8;
  localparam logic [0:0]  S_FILL = 1'b0;
  localparam logic [0:0]  S_HOLD = 1'b1;

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [3:0]           fill_nxt;
  logic [CNTWIDTH-1:0]  win_nxt;
  logic                 accept;
  logic                 load_slot;
  logic                 load_sa;
  logic [DATAWIDTH-1:0] slot [NSLOTS];

  assign accept = in_valid & in_ready;

  // Next state: flush beats a same-cycle sample in FILL, handshake beats flush in HOLD
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_level;
    win_nxt   = win_count;
    load_slot = 1'b0;
    load_sa   = 1'b0;
    case (state)
      S_FILL: begin
        if (flush) begin
          fill_nxt = 4'd0;
        end else if (accept) begin
          load_slot = 1'b1;
          load_sa   = (fill_level == 4'd0);
          if (fill_level == 4'd7) begin
            state_nxt = S_HOLD;
            fill_nxt  = 4'd8;
          end else begin
            fill_nxt = fill_level + 4'd1;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_nxt = S_FILL;
          fill_nxt  = 4'd0;
          win_nxt   = win_count + CNTWIDTH'(1);
        end else if (flush) begin
          state_nxt = S_FILL;
          fill_nxt  = 4'd0;
        end
      end
      default: begin
        state_nxt = S_FILL;
        fill_nxt  = 4'd0;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they track state exactly
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_FILL;
      fill_level <= 4'd0;
      win_count  <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      fill_level <= fill_nxt;
      win_count  <= win_nxt;
      in_ready   <= (state_nxt == S_FILL);
      out_valid  <= (state_nxt == S_HOLD);
    end
  end

  // Window storage; slots are never cleared between windows, only overwritten
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NSLOTS; i++) slot[i] <= '0;
      sa <= '0;
    end else begin
      if (load_slot) slot[fill_level[2:0]] <= in_data;
      if (load_sa)   sa <= sa_in;
    end
  end

  assign a = slot[0];
  assign b = slot[1];
  assign c = slot[2];
  assign d = slot[3];
  assign e = slot[4];
  assign f = slot[5];
  assign g = slot[6];
  assign h = slot[7];

endmodule

// File: tb/tb_sample_window_collector.sv
// Scoreboard bench for sample_window_collector: a queue-based window model predicts
// every handshake flag, fill level and delivered window; a negedge monitor compares.
module tb_sample_window_collector;

  localparam int unsigned DW  = 16;
  localparam int unsigned SW  = 8;
  localparam int unsigned CW  = 8;
  localparam int unsigned CKW = 8 * DW + SW;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] sa_in;
  logic          flush;
  logic [DW-1:0] a, b, c, d, e, f, g, h;
  logic [SW-1:0] sa;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    fill_level;
  logic [CW-1:0] win_count;

  always #5 Clk = ~Clk;

  sample_window_collector #(.DATAWIDTH(DW), .SAWIDTH(SW), .CNTWIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sa_in(sa_in), .flush(flush), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .sa(sa), .out_valid(out_valid), .out_ready(out_ready), .fill_level(fill_level),
    .win_count(win_count)
  );

  typedef struct packed {
    logic [8*DW-1:0] d;
    logic [SW-1:0]   sa;
  } win_t;

  // Reference model: partial window as a list, finished windows in the scoreboard
  win_t          sb[$];
  logic [DW-1:0] m_part[$];
  logic [SW-1:0] m_sa;
  bit            m_held;
  logic [CW-1:0] m_cnt;
  int unsigned   m_delivered;

  logic          cur_ready, cur_valid;
  logic [3:0]    cur_fill;
  logic [CW-1:0] cur_cnt;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_en  = 1'b0;

  task automatic check(input string name, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_part.delete();
    m_sa        = '0;
    m_held      = 1'b0;
    m_cnt       = '0;
    m_delivered = 0;
  endtask

  // Drive one cycle of inputs and advance the model to the state after the next edge
  task automatic step(input logic v, input logic [DW-1:0] dat, input logic [SW-1:0] s,
                      input logic fl, input logic rdy);
    win_t w;
    cur_ready = !m_held;
    cur_valid = m_held;
    cur_fill  = m_held ? 4'd8 : 4'(m_part.size());
    cur_cnt   = m_cnt;
    in_valid  = v;
    in_data   = dat;
    sa_in     = s;
    flush     = fl;
    out_ready = rdy;
    if (m_held) begin
      if (rdy) begin
        m_held = 1'b0;
        m_cnt  = m_cnt + CW'(1);
        m_delivered++;
      end else if (fl) begin
        m_held = 1'b0;
        void'(sb.pop_back());
      end
    end else if (fl) begin
      m_part.delete();
    end else if (v) begin
      if (m_part.size() == 0) m_sa = s;
      m_part.push_back(dat);
      if (m_part.size() == 8) begin
        for (int k = 0; k < 8; k++) w.d[DW*k +: DW] = m_part[k];
        w.sa = m_sa;
        sb.push_back(w);
        m_part.delete();
        m_held = 1'b1;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic fill8(input logic [DW-1:0] base, input logic [SW-1:0] s, input logic rdy);
    for (int k = 0; k < 8; k++) step(1'b1, base + DW'(k), s, 1'b0, rdy);
  endtask

  // Monitor: per-cycle flags vs model, windows popped on every handshake
  always @(negedge Clk) begin
    win_t w;
    if (chk_en && !Rst) begin
      check("in_ready", CKW'(in_ready), CKW'(cur_ready));
      check("out_valid", CKW'(out_valid), CKW'(cur_valid));
      check("fill_level", CKW'(fill_level), CKW'(cur_fill));
      check("win_count", CKW'(win_count), CKW'(cur_cnt));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_window: got window with sa %0h expected none", sa);
        end else begin
          w = sb.pop_front();
          check("window", CKW'({h, g, f, e, d, c, b, a}), CKW'(w.d));
          check("window_sa", CKW'(sa), CKW'(w.sa));
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, CKW'(out_valid), CKW'(0));
    check({tag, "_fill"}, CKW'(fill_level), CKW'(0));
    check({tag, "_win_count"}, CKW'(win_count), CKW'(0));
    check({tag, "_slots"}, CKW'({h, g, f, e, d, c, b, a}), CKW'(0));
    check({tag, "_sa"}, CKW'(sa), CKW'(0));
  endtask

  initial begin
    int cyc;
    Rst = 1'b1; in_valid = 1'b0; in_data = '0; sa_in = '0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    @(posedge Clk); #1;
    check_reset_values("reset");
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    check("reset_in_ready", CKW'(in_ready), CKW'(1));
    @(posedge Clk); #1;
    chk_en = 1'b1;

    // Basic fill 1..8, consumer always ready
    fill8(16'd1, 8'd1, 1'b1);
    check("avg_of_window", CKW'((a + b + c + d + e + f + g + h) >> 3), CKW'(4));
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Backpressure: five offered samples must be refused while held
    fill8(16'h0021, 8'd3, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, DW'($urandom), 8'd9, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Flush in FILL drops the partial window and the sample offered with it
    for (int k = 0; k < 3; k++) step(1'b1, 16'h0050 + DW'(k), 8'd7, 1'b0, 1'b1);
    step(1'b1, 16'h00aa, 8'd7, 1'b1, 1'b1);
    fill8(16'h0010, 8'd4, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    // Flush in HOLD without ready drops; with ready the window is delivered
    fill8(16'h0100, 8'd6, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    fill8(16'h0200, 8'd8, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1);

    // sa taken from the first sample only
    step(1'b1, 16'h0300, 8'd2, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) step(1'b1, 16'h0300 + DW'(k), 8'd5, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    // Asynchronous reset while a window is held
    fill8(16'h0400, 8'd1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    Rst = 1'b1;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Random traffic until the window counter has wrapped
    cyc = 0;
    while (m_delivered < 270 && cyc < 40000) begin
      step(($urandom_range(0, 99) < 75), DW'($urandom), SW'($urandom),
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60));
      cyc++;
    end
    n_tests++;
    if (m_delivered < 270) begin
      n_fail++;
      $display("FAIL wrap_budget: got %0d windows expected 270", m_delivered);
    end

    for (int k = 0; k < 4; k++) step(1'b0, '0, '0, 1'b0, 1'b1);
    check("scoreboard_drained", CKW'(sb.size()), CKW'(0));
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
